// File: rtl/spec_free_list_pkg.sv
// Shared types and sizing for the speculative free list of physical register tags.
package fl_pkg;
    localparam int PHYS_W   = 7;
    localparam int NUM_PHYS = 96;
    localparam int NUM_ARCH = 32;
    localparam int DEPTH    = NUM_PHYS - NUM_ARCH;
    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_W    = PTR_W + 1;

    typedef logic [PHYS_W-1:0] phys_tag_t;

    typedef enum logic {
        NORMAL  = 1'b0,
        RECOVER = 1'b1
    } fl_state_e;
endpackage

// File: rtl/spec_free_list_if.sv
// Release (commit side), allocation (rename side) and recovery signals of the free list.
interface spec_free_list_if;
    import fl_pkg::*;

    logic                 recoverFlag_i;
    logic                 releasedValid0_i;
    logic                 releasedValid1_i;
    logic                 releasedValid2_i;
    logic                 releasedValid3_i;
    phys_tag_t            releasedPhyMap0_i;
    phys_tag_t            releasedPhyMap1_i;
    phys_tag_t            releasedPhyMap2_i;
    phys_tag_t            releasedPhyMap3_i;
    logic [2:0]           popCount_i;
    phys_tag_t            freeReg0_o;
    phys_tag_t            freeReg1_o;
    phys_tag_t            freeReg2_o;
    phys_tag_t            freeReg3_o;
    logic                 popReady_o;
    logic [CNT_W-1:0]     freeCnt_o;
    logic                 overflowErr_o;

    modport master (
        output recoverFlag_i,
        output releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i,
        output releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i,
        output popCount_i,
        input  freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o,
        input  popReady_o, freeCnt_o, overflowErr_o
    );

    modport slave (
        input  recoverFlag_i,
        input  releasedValid0_i, releasedValid1_i, releasedValid2_i, releasedValid3_i,
        input  releasedPhyMap0_i, releasedPhyMap1_i, releasedPhyMap2_i, releasedPhyMap3_i,
        input  popCount_i,
        output freeReg0_o, freeReg1_o, freeReg2_o, freeReg3_o,
        output popReady_o, freeCnt_o, overflowErr_o
    );
endinterface

// File: rtl/spec_free_list_release_compact.sv
// Combinational 4-to-4 packer: moves valid released tags to the low slots in port order.
module release_compact
    import fl_pkg::*;
(
    input  logic [3:0] valid,
    input  phys_tag_t  tag        [4],
    output phys_tag_t  packed_tag [4],
    output logic [3:0] wr_en,
    output logic [2:0] push_n
);
    logic [2:0] slot;

    always_comb begin
        slot = 3'd0;
        for (int s = 0; s < 4; s++) begin
            packed_tag[s] = '0;
        end
        for (int k = 0; k < 4; k++) begin
            if (valid[k]) begin
                packed_tag[slot[1:0]] = tag[k];
                slot = slot + 3'd1;
            end
        end
    end

    always_comb begin
        for (int s = 0; s < 4; s++) begin
            wr_en[s] = (3'(s) < slot);
        end
    end

    assign push_n = slot;
endmodule

// File: rtl/spec_free_list.sv
// Speculative free list: circular tag buffer with rename-side head, commit-side head and tail.
module spec_free_list #(
    parameter int PHYS_W   = fl_pkg::PHYS_W,
    parameter int NUM_PHYS = fl_pkg::NUM_PHYS,
    parameter int NUM_ARCH = fl_pkg::NUM_ARCH
) (
    input logic             clk,
    input logic             reset,
    spec_free_list_if.slave fl
);
    localparam int DEPTH = NUM_PHYS - NUM_ARCH;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_X = (CNT_W+1)'(DEPTH);

    logic [PHYS_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [PTR_W-1:0]  commit_head;
    logic [CNT_W-1:0]  free_cnt;
    logic              overflow_err;

    fl_pkg::fl_state_e state;
    fl_pkg::fl_state_e state_next;
    logic              pop_allow;
    logic              track_commit;

    logic [3:0]        rel_valid;
    fl_pkg::phys_tag_t rel_tag    [4];
    fl_pkg::phys_tag_t packed_tag [4];
    logic [3:0]        wr_en;
    logic [2:0]        push_n;

    assign rel_valid = {fl.releasedValid3_i, fl.releasedValid2_i,
                        fl.releasedValid1_i, fl.releasedValid0_i};
    assign rel_tag[0] = fl.releasedPhyMap0_i;
    assign rel_tag[1] = fl.releasedPhyMap1_i;
    assign rel_tag[2] = fl.releasedPhyMap2_i;
    assign rel_tag[3] = fl.releasedPhyMap3_i;

    release_compact u_compact (
        .valid      (rel_valid),
        .tag        (rel_tag),
        .packed_tag (packed_tag),
        .wr_en      (wr_en),
        .push_n     (push_n)
    );

    always_ff @(posedge clk) begin
        if (reset) state <= fl_pkg::NORMAL;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            fl_pkg::NORMAL:  if (fl.recoverFlag_i)  state_next = fl_pkg::RECOVER;
            fl_pkg::RECOVER: if (!fl.recoverFlag_i) state_next = fl_pkg::NORMAL;
            default:         state_next = fl_pkg::NORMAL;
        endcase
    end

    // While recovering (including the entry and exit cycles) head follows commit_head.
    always_comb begin
        pop_allow    = 1'b0;
        track_commit = 1'b0;
        case (state)
            fl_pkg::NORMAL: begin
                if (fl.recoverFlag_i) track_commit = 1'b1;
                else                  pop_allow    = 1'b1;
            end
            fl_pkg::RECOVER: track_commit = 1'b1;
            default:         track_commit = 1'b1;
        endcase
    end

    logic             pop_ready;
    logic [2:0]       pop_req;
    logic [2:0]       pop_n;
    logic [CNT_W:0]   cnt_plus;
    logic [CNT_W:0]   cnt_net;
    logic             overflow;
    logic [CNT_W-1:0] cnt_next;

    assign pop_ready = (free_cnt >= CNT_W'(4)) && (state == fl_pkg::NORMAL);
    assign pop_req   = (fl.popCount_i > 3'd4) ? 3'd4 : fl.popCount_i;
    assign pop_n     = (pop_allow && pop_ready) ? pop_req : 3'd0;
    assign cnt_plus  = {1'b0, free_cnt} + (CNT_W+1)'(push_n);
    assign cnt_net   = cnt_plus - (CNT_W+1)'(pop_n);
    assign overflow  = !track_commit && (cnt_plus > DEPTH_X);

    always_comb begin
        cnt_next = cnt_net[CNT_W-1:0];
        if (track_commit || (cnt_net > DEPTH_X)) cnt_next = CNT_W'(DEPTH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head         <= '0;
            tail         <= '0;
            commit_head  <= '0;
            free_cnt     <= CNT_W'(DEPTH);
            overflow_err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= PHYS_W'(NUM_ARCH + i);
            end
        end else begin
            tail        <= tail + PTR_W'(push_n);
            commit_head <= commit_head + PTR_W'(push_n);
            head        <= track_commit ? (commit_head + PTR_W'(push_n))
                                        : (head + PTR_W'(pop_n));
            free_cnt    <= cnt_next;
            if (overflow) overflow_err <= 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (wr_en[k]) mem[tail + PTR_W'(k)] <= packed_tag[k];
            end
        end
    end

    assign fl.freeReg0_o    = mem[head];
    assign fl.freeReg1_o    = mem[head + PTR_W'(1)];
    assign fl.freeReg2_o    = mem[head + PTR_W'(2)];
    assign fl.freeReg3_o    = mem[head + PTR_W'(3)];
    assign fl.popReady_o    = pop_ready;
    assign fl.freeCnt_o     = free_cnt;
    assign fl.overflowErr_o = overflow_err;
endmodule

// File: tb/tb_spec_free_list.sv
// Directed bench for spec_free_list: allocation, release, wrap, recovery, reset and overflow.
module tb_spec_free_list;
    import fl_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    spec_free_list_if fl_bus ();

    spec_free_list dut (
        .clk   (clk),
        .reset (reset),
        .fl    (fl_bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic release_tags(input logic [3:0] v, input int t0, input int t1,
                                input int t2, input int t3);
        fl_bus.releasedValid0_i  = v[0];
        fl_bus.releasedValid1_i  = v[1];
        fl_bus.releasedValid2_i  = v[2];
        fl_bus.releasedValid3_i  = v[3];
        fl_bus.releasedPhyMap0_i = PHYS_W'(t0);
        fl_bus.releasedPhyMap1_i = PHYS_W'(t1);
        fl_bus.releasedPhyMap2_i = PHYS_W'(t2);
        fl_bus.releasedPhyMap3_i = PHYS_W'(t3);
    endtask

    task automatic idle();
        release_tags(4'b0000, 0, 0, 0, 0);
        fl_bus.popCount_i    = 3'd0;
        fl_bus.recoverFlag_i = 1'b0;
    endtask

    task automatic check_regs(input string tag, input int r0, input int r1,
                              input int r2, input int r3);
        check({tag, "_reg0"}, 32'(fl_bus.freeReg0_o), r0);
        check({tag, "_reg1"}, 32'(fl_bus.freeReg1_o), r1);
        check({tag, "_reg2"}, 32'(fl_bus.freeReg2_o), r2);
        check({tag, "_reg3"}, 32'(fl_bus.freeReg3_o), r3);
    endtask

    // tail and commit_head advance together, so they must always be equal outside reset.
    always @(negedge clk) begin
        if (!reset) begin
            assert (dut.tail == dut.commit_head)
            else check("ptr_invariant", 32'(dut.tail), 32'(dut.commit_head));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        idle();
        step();
        step();
        reset = 1'b0;
        check("rst_ready", 32'(fl_bus.popReady_o), 1);
        check("rst_cnt", 32'(fl_bus.freeCnt_o), 64);
        check("rst_err", 32'(fl_bus.overflowErr_o), 0);
        check_regs("rst", 32, 33, 34, 35);

        fl_bus.popCount_i = 3'd4;
        step();
        fl_bus.popCount_i = 3'd0;
        check_regs("pop4", 36, 37, 38, 39);
        check("pop4_cnt", 32'(fl_bus.freeCnt_o), 60);

        release_tags(4'b1010, 0, 5, 0, 9);
        step();
        idle();
        check("rel_mem0", 32'(dut.mem[0]), 5);
        check("rel_mem1", 32'(dut.mem[1]), 9);
        check("rel_tail", 32'(dut.tail), 2);
        check("rel_cnt", 32'(fl_bus.freeCnt_o), 62);
        check("rel_head", 32'(dut.head), 4);

        // one of these requests is 7, which must behave as 4
        for (int i = 0; i < 13; i++) begin
            fl_bus.popCount_i = (i == 5) ? 3'd7 : 3'd4;
            step();
        end
        check("drain_head", 32'(dut.head), 56);
        check("drain_cnt", 32'(fl_bus.freeCnt_o), 10);
        fl_bus.popCount_i = 3'd2;
        step();
        fl_bus.popCount_i = 3'd4;
        step();
        fl_bus.popCount_i = 3'd0;
        check("wrap_head", 32'(dut.head), 62);
        check("wrap_ready", 32'(fl_bus.popReady_o), 1);
        check_regs("wrap", 94, 95, 5, 9);

        fl_bus.popCount_i = 3'd1;
        step();
        check("low_cnt", 32'(fl_bus.freeCnt_o), 3);
        check("low_ready", 32'(fl_bus.popReady_o), 0);
        fl_bus.popCount_i = 3'd2;
        step();
        fl_bus.popCount_i = 3'd0;
        check("ign_head", 32'(dut.head), 63);
        check("ign_cnt", 32'(fl_bus.freeCnt_o), 3);

        release_tags(4'b1111, 40, 41, 42, 43);
        step();
        release_tags(4'b0111, 44, 45, 46, 0);
        step();
        check("fill_cnt", 32'(fl_bus.freeCnt_o), 10);
        release_tags(4'b1111, 50, 51, 52, 53);
        fl_bus.popCount_i = 3'd4;
        step();
        idle();
        check("both_cnt", 32'(fl_bus.freeCnt_o), 10);
        check("both_tail", 32'(dut.tail), 13);
        check("both_chead", 32'(dut.commit_head), 13);
        check("both_head", 32'(dut.head), 3);
        check("both_err", 32'(fl_bus.overflowErr_o), 0);
        check("both_mem9", 32'(dut.mem[9]), 50);
        check_regs("both", 41, 42, 43, 44);

        reset = 1'b1;
        step();
        reset = 1'b0;
        fl_bus.popCount_i = 3'd4;
        for (int i = 0; i < 3; i++) step();
        check("spec_head", 32'(dut.head), 12);
        check("spec_cnt", 32'(fl_bus.freeCnt_o), 52);
        fl_bus.recoverFlag_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rec_cnt", 32'(fl_bus.freeCnt_o), 64);
            check("rec_ready", 32'(fl_bus.popReady_o), 0);
            check("rec_head", 32'(dut.head), 32'(dut.commit_head));
            check("rec_head0", 32'(dut.head), 0);
        end
        idle();
        check("rec_fall_ready", 32'(fl_bus.popReady_o), 0);
        step();
        check("rec_done_ready", 32'(fl_bus.popReady_o), 1);
        check("rec_done_reg0", 32'(fl_bus.freeReg0_o), 32);
        check("rec_done_cnt", 32'(fl_bus.freeCnt_o), 64);

        fl_bus.recoverFlag_i = 1'b1;
        release_tags(4'b0001, 7, 0, 0, 0);
        step();
        release_tags(4'b0000, 0, 0, 0, 0);
        check("recpush_head", 32'(dut.head), 1);
        check("recpush_tail", 32'(dut.tail), 1);
        check("recpush_cnt", 32'(fl_bus.freeCnt_o), 64);
        check("recpush_mem0", 32'(dut.mem[0]), 7);

        reset = 1'b1;
        step();
        reset = 1'b0;
        idle();
        check("midrst_cnt", 32'(fl_bus.freeCnt_o), 64);
        check("midrst_head", 32'(dut.head), 0);
        check("midrst_tail", 32'(dut.tail), 0);
        check("midrst_ready", 32'(fl_bus.popReady_o), 1);
        check_regs("midrst", 32, 33, 34, 35);

        release_tags(4'b0001, 3, 0, 0, 0);
        step();
        idle();
        check("ovf_err", 32'(fl_bus.overflowErr_o), 1);
        check("ovf_cnt", 32'(fl_bus.freeCnt_o), 64);
        step();
        check("ovf_sticky", 32'(fl_bus.overflowErr_o), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/spec_free_list.md
# spec_free_list

Speculative free list of physical register tags for the rename stage. It is the receiving end of the Architecture Map Table release interface: it accepts up to 4 released physical tags per cycle at commit and supplies up to 4 free tags per cycle to rename. On a branch mispredict or exception it restores all speculatively allocated tags in one cycle, using a commit-side head pointer.

## Interface
- `PHYS_W`, default `SIZE_PHYSICAL_LOG` (7): physical tag width.
- `NUM_PHYS`, default `SIZE_PHYSICAL_TABLE` (96): number of physical registers.
- `NUM_ARCH`, default `SIZE_RMT` (32): number of logical registers.
- `DEPTH`, derived as `NUM_PHYS-NUM_ARCH` (64); must be a power of 2. `PTR_W = log2(DEPTH)`, `CNT_W = PTR_W+1`.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `recoverFlag_i` in 1: recovery request from ActiveList; held high for 1 or more cycles.
- `releasedValid0_i`..`releasedValid3_i` in 1 each: release valid; any bit pattern is allowed.
- `releasedPhyMap0_i`..`releasedPhyMap3_i` in PHYS_W each: released tag.
- `popCount_i` in 3: number of tags rename consumes this cycle (0..4).
- `freeReg0_o`..`freeReg3_o` out PHYS_W each: tags at head, head+1, head+2, head+3.
- `popReady_o` out 1: high when `freeCnt>=4` and the block is not in RECOVER.
- `freeCnt_o` out CNT_W: current free count.
- `overflowErr_o` out 1: sticky error; set if a push would exceed DEPTH.

## Operation
- Storage is a circular buffer `mem[DEPTH]` of tags. Registered pointers: `head`, `tail`, `commitHead`, all PTR_W and wrapping modulo DEPTH. Counter: `freeCnt`, CNT_W.
- Reset state:
  - `mem[i] = NUM_ARCH+i`.
  - `head = commitHead = tail = 0`.
  - `freeCnt = DEPTH`.
  - `overflowErr_o = 0`.
  - state NORMAL.
- Outputs after reset: `popReady_o=1`, `freeCnt_o=64`, `freeReg0..3_o = 32,33,34,35`.
- Push:
  - `pushN = popcount(releasedValid*)`.
  - Valid tags are compacted in port order (lowest port first) and written to `mem[tail]..mem[tail+pushN-1]`.
  - `tail += pushN`.
- Commit advance: each release corresponds to one committed instruction with a destination, which consumed a tag at rename in program order. Therefore `commitHead += pushN`.
- Pop:
  - Effective pop `popN = popCount_i` when `popReady_o` is high, else 0.
  - A pop while `popReady_o` is low is ignored. A `popCount_i` value greater than 4 is treated as 4.
  - `head += popN`.
- Count update in NORMAL: `freeCnt_next = freeCnt + pushN - popN`.
- If `freeCnt + pushN > DEPTH`, set `overflowErr_o` and saturate `freeCnt` at DEPTH.
- State machine:
  - NORMAL -> RECOVER when `recoverFlag_i=1`. In that same edge: `head <= commitHead + pushN`, `freeCnt <= DEPTH`, and pops are suppressed.
  - RECOVER holds while `recoverFlag_i=1`. Pops are suppressed; pushes still update `tail` and `commitHead`, and `head` tracks `commitHead` as well.
  - RECOVER -> NORMAL on the first cycle with `recoverFlag_i=0`.
- Invariant: `tail - commitHead == DEPTH mod DEPTH` (the pointers are equal) whenever `freeCnt` plus in-flight allocations equals DEPTH. A bench checks this with an assertion.

## Timing
- Push and pop take effect at the clock edge. A pushed tag can appear on `freeReg*_o` in the next cycle at the earliest.
- `freeReg*_o` and `popReady_o` are combinational from registered state. They do not depend on the current cycle's push or pop.
- Simultaneous push and pop: both apply, and the count uses the net change.
- Wrap-around: all index arithmetic is modulo DEPTH. Entries `head+k` wrap past `DEPTH-1` to 0.
- Recovery has 1-cycle latency: in the cycle after `recoverFlag_i` rises, `freeCnt_o = DEPTH` and `popReady_o = 0` until the flag falls.
- Asserting reset in the middle of recovery or of a push returns the block to the full reset state at the next edge.

## Structure
- Shared package `fl_pkg`: `PHYS_W`, `DEPTH`, `PTR_W`, `CNT_W`, `typedef phys_tag_t`, and the NORMAL/RECOVER state enum.
- Sub-module `release_compact`: a combinational 4-to-4 packer. It outputs the compacted tags, per-slot write enables, and `pushN`.
- Top level: pointer registers, count, FSM, and the memory.

## Test plan
- Reset, then `popCount_i=4` for 1 cycle: the next cycle shows `freeReg0..3_o = 36..39` and `freeCnt_o = 60`.
- Release with `releasedValid = 4'b1010`, tags 5 and 9, with `freeCnt = 60`: `mem[0]=5` and `mem[1]=9`, `tail=2`, `freeCnt=62`.
- Pop down to `freeCnt = 3`:
  - Expect `popReady_o = 0`.
  - Apply `popCount_i = 2`: expect no change in `head` or `freeCnt`.
- Wrap: with `head = 62`, expect `freeReg0..3_o` to read `mem[62], mem[63], mem[0], mem[1]`.
- Recovery:
  - Pop 12 tags with no commits, then raise `recoverFlag_i` for 3 cycles.
  - Expect `freeCnt_o = 64`, `head = commitHead`, and `popReady_o = 0` during the flag.
  - One cycle after the flag falls, expect `popReady_o = 1` and `freeReg0_o` equal to the first tag popped.
- Simultaneous 4 releases and a pop of 4 with `freeCnt = 10`: `freeCnt` stays 10, and `tail`, `head`, and `commitHead` each advance by 4 with no error.
